// File: rtl/imm_ext_pkg.sv
// Shared mode encoding for the immediate-extension pipeline.
package imm_ext_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_SIGN   = 2'b00;
  localparam ext_mode_t EXT_ZERO   = 2'b01;
  localparam ext_mode_t EXT_UPPER  = 2'b10;
  localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_stage.sv
// One valid/data register slice of the extension pipeline.
// en means "this slice is empty or its content advances this cycle".
module imm_ext_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         en,
  input  logic         v_in,
  input  logic [W-1:0] d_in,
  output logic         v,
  output logic [W-1:0] d
);

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (en) begin
      v <= v_in;
      if (v_in) d <= d_in;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extension (sign/zero/upper/branch) behind DEPTH valid/ready stages.
// Define IMM_EXT_ZERO_FLAG_EN to add the registered all-zero flag output Ext_Zero.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [IN_W-1:0]  Immed_In,
  input  ext_mode_t        Ext_Mode,
  output logic             Out_Valid,
  input  logic             Out_Ready,
`ifdef IMM_EXT_ZERO_FLAG_EN
  output logic             Ext_Zero,
`endif
  output logic [OUT_W-1:0] Ext_Immed_Out
);

`ifdef IMM_EXT_ZERO_FLAG_EN
  localparam int SW = OUT_W + 1;
`else
  localparam int SW = OUT_W;
`endif
  localparam int PAD = OUT_W - IN_W;

  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
  end
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("imm_extend_pipe: DEPTH must be in 1..4");
  end

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  logic [SW-1:0]    stage_in;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [SW-1:0]    d [DEPTH];

  assign sext = {{PAD{Immed_In[IN_W-1]}}, Immed_In};

  always_comb begin
    ext = sext;
    case (Ext_Mode)
      EXT_SIGN:   ext = sext;
      EXT_ZERO:   ext = {{PAD{1'b0}}, Immed_In};
      EXT_UPPER:  ext = {Immed_In, {PAD{1'b0}}};
      EXT_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
      default:    ext = sext;
    endcase
  end

`ifdef IMM_EXT_ZERO_FLAG_EN
  assign stage_in = {(ext == '0), ext};
`else
  assign stage_in = ext;
`endif

  // The recursive advance chain unrolls to: a full stage moves when the output
  // drains or any later stage is empty; computed flat to avoid a comb chain.
  always_comb begin
    logic hole;
    adv  = '0;
    hole = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      hole = Out_Ready;
      for (int j = k + 1; j < DEPTH; j++) hole = hole | !v[j];
      adv[k] = v[k] & hole;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          v_in;
    logic [SW-1:0] d_in;
    if (k == 0) begin : g_head
      assign v_in = In_Valid;
      assign d_in = stage_in;
    end else begin : g_link
      assign v_in = v[k-1];
      assign d_in = d[k-1];
    end
    imm_ext_stage #(.W(SW)) u_stage (
      .clk   (Clk),
      .rst   (Rst),
      .flush (Flush),
      .en    (!v[k] | adv[k]),
      .v_in  (v_in),
      .d_in  (d_in),
      .v     (v[k]),
      .d     (d[k])
    );
  end

  assign In_Ready      = !v[0] | adv[0];
  assign Out_Valid     = v[DEPTH-1];
  assign Ext_Immed_Out = d[DEPTH-1][OUT_W-1:0];
`ifdef IMM_EXT_ZERO_FLAG_EN
  assign Ext_Zero      = d[DEPTH-1][OUT_W];
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench: DEPTH=1 instance for the extension modes, DEPTH=3 instance for
// streaming, backpressure, flush and mid-stall reset.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // DEPTH=1 instance
  logic        a_rst, a_flush, a_iv, a_ir, a_ov, a_ordy;
  logic [15:0] a_imm;
  ext_mode_t   a_mode;
  logic [31:0] a_out;
`ifdef IMM_EXT_ZERO_FLAG_EN
  logic        a_zero;
`endif

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(1)) u_d1 (
    .Clk           (clk),
    .Rst           (a_rst),
    .Flush         (a_flush),
    .In_Valid      (a_iv),
    .In_Ready      (a_ir),
    .Immed_In      (a_imm),
    .Ext_Mode      (a_mode),
    .Out_Valid     (a_ov),
    .Out_Ready     (a_ordy),
`ifdef IMM_EXT_ZERO_FLAG_EN
    .Ext_Zero      (a_zero),
`endif
    .Ext_Immed_Out (a_out)
  );

  // DEPTH=3 instance
  logic        b_rst, b_flush, b_iv, b_ir, b_ov, b_ordy;
  logic [15:0] b_imm;
  ext_mode_t   b_mode;
  logic [31:0] b_out;
`ifdef IMM_EXT_ZERO_FLAG_EN
  logic        b_zero;
`endif

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(3)) u_d3 (
    .Clk           (clk),
    .Rst           (b_rst),
    .Flush         (b_flush),
    .In_Valid      (b_iv),
    .In_Ready      (b_ir),
    .Immed_In      (b_imm),
    .Ext_Mode      (b_mode),
    .Out_Valid     (b_ov),
    .Out_Ready     (b_ordy),
`ifdef IMM_EXT_ZERO_FLAG_EN
    .Ext_Zero      (b_zero),
`endif
    .Ext_Immed_Out (b_out)
  );

  // Mode vectors for DEPTH=1: immediate, mode, expected result, expected zero flag
  logic [15:0] va_imm  [9] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h0000,
                               16'h4000, 16'h7FFF, 16'hC000, 16'h0001};
  ext_mode_t   va_mode [9] = '{EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BRANCH, EXT_SIGN,
                               EXT_BRANCH, EXT_SIGN, EXT_BRANCH, EXT_UPPER};
  logic [31:0] va_exp  [9] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004,
                               32'h00000000, 32'h00010000, 32'h00007FFF, 32'hFFFF0000,
                               32'h00010000};
  logic        va_zero [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // Stream bookkeeping for the DEPTH=3 instance
  logic [15:0] tx[$];
  logic [15:0] rx_exp[$];
  int          tx_i, rx_i, acc_cnt, rdy_drops, first_out, last_out, cyc;
  logic        b_acc;

  task automatic b_clear();
    tx.delete();
    rx_exp.delete();
    tx_i = 0; rx_i = 0; acc_cnt = 0; rdy_drops = 0;
    first_out = -1; last_out = -1; cyc = 0; b_acc = 1'b0;
  endtask

  task automatic b_cycle(input logic ordy, input logic fl, input logic rs);
    @(posedge clk); #1;
    if (b_acc) tx_i++;
    b_iv    = (tx_i < tx.size());
    b_imm   = b_iv ? tx[tx_i] : 16'h0;
    b_mode  = EXT_ZERO;
    b_ordy  = ordy;
    b_flush = fl;
    b_rst   = rs;
    @(negedge clk);
    b_acc = b_iv && b_ir && !rs;
    if (b_acc) acc_cnt++;
    if (b_iv && !b_ir) rdy_drops++;
    if (b_ov) begin
      if (b_ordy) begin
        if (rx_i < rx_exp.size()) check("b_out", b_out, {16'h0, rx_exp[rx_i]});
        else check("b_extra_out", 32'(b_ov), 32'd0);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        rx_i++;
      end else if (rx_i < rx_exp.size()) begin
        check("b_stall_hold", b_out, {16'h0, rx_exp[rx_i]});
      end
    end
    cyc++;
  endtask

  // Upstream must hold a refused offer stable until accepted
  logic        prev_iv = 1'b0, prev_ir = 1'b1, prev_rst = 1'b1;
  logic [15:0] prev_imm = '0;
  ext_mode_t   prev_mode = EXT_SIGN;
  always @(negedge clk) begin
    if (prev_iv && !prev_ir && !prev_rst)
      assert (b_iv && b_imm == prev_imm && b_mode == prev_mode)
        else $error("upstream hold violated");
    prev_iv   <= b_iv;
    prev_ir   <= b_ir;
    prev_rst  <= b_rst;
    prev_imm  <= b_imm;
    prev_mode <= b_mode;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_iv = 1'b0; a_imm = '0; a_mode = EXT_SIGN; a_ordy = 1'b1;
    b_rst = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_imm = '0; b_mode = EXT_ZERO; b_ordy = 1'b1;
    b_clear();
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;

    @(negedge clk);
    check("a_rst_ov",  32'(a_ov), 32'd0);
    check("a_rst_out", a_out, 32'd0);
    check("a_rst_ir",  32'(a_ir), 32'd1);
    check("b_rst_ov",  32'(b_ov), 32'd0);
    check("b_rst_out", b_out, 32'd0);
    check("b_rst_ir",  32'(b_ir), 32'd1);
`ifdef IMM_EXT_ZERO_FLAG_EN
    check("a_rst_zero", 32'(a_zero), 32'd0);
`endif

    // DEPTH=1: each mode, result one cycle after transfer
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      a_iv = 1'b1; a_imm = va_imm[i]; a_mode = va_mode[i];
      @(posedge clk); #1;
      a_iv = 1'b0;
      @(negedge clk);
      check($sformatf("a_ov_%0d", i), 32'(a_ov), 32'd1);
      check($sformatf("a_out_%0d", i), a_out, va_exp[i]);
`ifdef IMM_EXT_ZERO_FLAG_EN
      check($sformatf("a_zero_%0d", i), 32'(a_zero), 32'(va_zero[i]));
`endif
    end

    // DEPTH=3: back-to-back stream 1..8
    b_clear();
    for (int i = 1; i <= 8; i++) begin
      tx.push_back(16'(i));
      rx_exp.push_back(16'(i));
    end
    repeat (12) b_cycle(1'b1, 1'b0, 1'b0);
    check("b2b_rdy_drops", 32'(rdy_drops), 32'd0);
    check("b2b_first_out", 32'(first_out), 32'd3);
    check("b2b_last_out",  32'(last_out), 32'd10);
    check("b2b_count",     32'(rx_i), 32'd8);

    // DEPTH=3: backpressure fills exactly 3, then drains in order
    b_clear();
    for (int i = 11; i <= 16; i++) begin
      tx.push_back(16'(i));
      rx_exp.push_back(16'(i));
    end
    repeat (6) b_cycle(1'b0, 1'b0, 1'b0);
    check("stall_accepts", 32'(acc_cnt), 32'd3);
    check("stall_ir",      32'(b_ir), 32'd0);
    check("stall_ov",      32'(b_ov), 32'd1);
    check("stall_out",     b_out, 32'd11);
    repeat (12) b_cycle(1'b1, 1'b0, 1'b0);
    check("drain_count",   32'(rx_i), 32'd6);
    check("drain_accepts", 32'(acc_cnt), 32'd6);

    // DEPTH=3: flush with two in flight plus an offer (value 23 is dropped)
    b_clear();
    tx = '{16'd21, 16'd22, 16'd23, 16'd24};
    rx_exp = '{16'd24};
    repeat (2) b_cycle(1'b1, 1'b0, 1'b0);
    b_cycle(1'b1, 1'b1, 1'b0);
    check("flush_ir", 32'(b_ir), 32'd1);
    b_cycle(1'b1, 1'b0, 1'b0);
    check("flush_ov", 32'(b_ov), 32'd0);
    repeat (8) b_cycle(1'b1, 1'b0, 1'b0);
    check("flush_first_out", 32'(first_out), 32'd6);
    check("flush_count",     32'(rx_i), 32'd1);

    // DEPTH=3: reset while stalled with a full pipe
    b_clear();
    for (int i = 31; i <= 36; i++) begin
      tx.push_back(16'(i));
      rx_exp.push_back(16'(i));
    end
    repeat (5) b_cycle(1'b0, 1'b0, 1'b0);
    check("full_ir", 32'(b_ir), 32'd0);
    check("full_ov", 32'(b_ov), 32'd1);
    b_cycle(1'b0, 1'b0, 1'b1);
    tx.delete();
    tx_i  = 0;
    b_acc = 1'b0;
    b_cycle(1'b0, 1'b0, 1'b0);
    check("rst_mid_ov",  32'(b_ov), 32'd0);
    check("rst_mid_out", b_out, 32'd0);
    check("rst_mid_ir",  32'(b_ir), 32'd1);
`ifdef IMM_EXT_ZERO_FLAG_EN
    check("rst_mid_zero", 32'(b_zero), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
